mac_param: RTL

MAC_PARAM -- requirements
Module: mac_param

---
 rtl/mac_param.sv | 109 ++++++++++
 1 files changed

// File: rtl/mac_param.sv
// Two-stage pipelined multiply-accumulate over groups of ACC_LEN operand pairs, with early flush.
// Define MAC_SIGNED_EN for two's-complement operands and result; otherwise everything is unsigned.
module mac_param #(
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned ACC_LEN = 4,
  localparam int unsigned ACC_W  = 2 * DATA_W + $clog2(ACC_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in1_IFM,
  input  logic [DATA_W-1:0] in2_IFM,
  input  logic              flush,
  output logic [ACC_W-1:0]  out,
  output logic              out_valid,
  output logic              busy
);

  localparam int unsigned CntW  = $clog2(ACC_LEN);
  localparam int unsigned ProdW = 2 * DATA_W;
  localparam int unsigned ExtW  = ACC_W - ProdW;

  logic [ProdW-1:0] mult;
  logic [ACC_W-1:0] prod_ext;

`ifdef MAC_SIGNED_EN
  // Low ProdW bits of the sign-extended product are exact in two's complement.
  assign mult = $signed({{DATA_W{in1_IFM[DATA_W-1]}}, in1_IFM})
              * $signed({{DATA_W{in2_IFM[DATA_W-1]}}, in2_IFM});
  assign prod_ext = {{ExtW{mult[ProdW-1]}}, mult};
`else
  assign mult     = {{DATA_W{1'b0}}, in1_IFM} * {{DATA_W{1'b0}}, in2_IFM};
  assign prod_ext = {{ExtW{1'b0}}, mult};
`endif

  logic [CntW-1:0]  count_q, count_d;
  logic             s1_valid_q, s1_valid_d;
  logic             s1_first_q, s1_first_d;
  logic             s1_last_q, s1_last_d;
  logic [ACC_W-1:0] s1_prod_q, s1_prod_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             s2_last_q, s2_last_d;
  logic [ACC_W-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;

  logic group_open;
  logic take;
  logic count_full;

  assign group_open = (count_q != '0);
  assign count_full = (count_q == CntW'(ACC_LEN - 1));
  // A flush with no sample closes an open group by injecting a zero product.
  assign take       = in_valid || (flush && group_open);

  // Stage 1: sample operands, tag first/last of group.
  always_comb begin
    count_d    = count_q;
    s1_valid_d = take;
    s1_first_d = !group_open;
    s1_last_d  = flush || count_full;
    s1_prod_d  = in_valid ? prod_ext : '0;
    if (take) begin
      count_d = s1_last_d ? '0 : count_q + CntW'(1);
    end
  end

  // Stage 2: accumulate; output register publishes the completed sum.
  always_comb begin
    acc_d       = acc_q;
    s2_last_d   = s1_valid_q && s1_last_q;
    out_d       = out_q;
    out_valid_d = s2_last_q;
    if (s1_valid_q) begin
      acc_d = s1_first_q ? s1_prod_q : acc_q + s1_prod_q;
    end
    if (s2_last_q) begin
      out_d = acc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_prod_q   <= '0;
      acc_q       <= '0;
      s2_last_q   <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s1_prod_q   <= s1_prod_d;
      acc_q       <= acc_d;
      s2_last_q   <= s2_last_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = group_open || s1_valid_q;

endmodule
